// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared state type and sizing for the serial deserializer (SHIFT_DESER_PARITY_EN adds a parity bit per frame)
package shift_pkg;

  localparam int DEFAULT_WIDTH = 64;

`ifdef SHIFT_DESER_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  typedef enum logic {
    RECV  = 1'b0,
    STALL = 1'b1
  } deser_state_t;

  function automatic int frame_bits(input int width);
    return width + PARITY_BITS;
  endfunction

endpackage

// File: rtl/deser_shift_core.sv
// rtl/deser_shift_core.sv - serial-in parallel-out shift register, newest bit at bit 0
module deser_shift_core #(
  parameter int WIDTH = 64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_ser,
  output logic [WIDTH-1:0] o_par
);

  logic [WIDTH-1:0] r_sr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr <= '0;
    end else if (i_clr) begin
      r_sr <= '0;
    end else if (i_en) begin
      r_sr <= {r_sr[WIDTH-2:0], i_ser};
    end
  end

  assign o_par = r_sr;

endmodule

// File: rtl/shift_deserializer_64bit.sv
// rtl/shift_deserializer_64bit.sv - serial-to-parallel deserializer with output handshake; SHIFT_DESER_PARITY_EN enables even-parity checking
module shift_deserializer_64bit
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Clear,
  input  logic             SerIn,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic [WIDTH-1:0] Out,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [6:0]       Count
`ifdef SHIFT_DESER_PARITY_EN
  ,
  output logic             Parity_Err
`endif
);

  localparam int FW = frame_bits(WIDTH);
  localparam logic [6:0] LAST = 7'(FW - 1);

  deser_state_t     r_state;
  logic [6:0]       r_count;
  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;

  logic          w_accept;
  logic          w_complete;
  logic          w_consume;
  logic          w_load;
  logic [FW-1:0] w_par;
  logic [FW-1:0] w_frame_now;
  logic [FW-1:0] w_frame_sel;

  assign w_accept   = In_Valid & (r_state == RECV);
  assign w_complete = w_accept & (r_count == LAST);
  assign w_consume  = r_out_valid & Out_Ready;

  // The completing bit is still on SerIn in RECV; in STALL it has already been shifted in.
  assign w_frame_now = {w_par[FW-2:0], SerIn};
  assign w_frame_sel = (r_state == STALL) ? w_par : w_frame_now;

  assign w_load = ~Clear & (((r_state == RECV) & w_complete & (~r_out_valid | Out_Ready)) |
                            ((r_state == STALL) & Out_Ready));

  deser_shift_core #(.WIDTH(FW)) u_core (
    .i_clk   (Clk),
    .i_rst_n (Reset),
    .i_en    (w_accept),
    .i_clr   (Clear),
    .i_ser   (SerIn),
    .o_par   (w_par)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state     <= RECV;
      r_count     <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (Clear) begin
      r_state <= RECV;
      r_count <= '0;
      if (w_consume) r_out_valid <= 1'b0;
    end else begin
      if (w_load) begin
        r_out       <= w_frame_sel[FW-1 -: WIDTH];
        r_out_valid <= 1'b1;
      end else if (w_consume) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        RECV: begin
          if (w_accept) r_count <= w_complete ? 7'd0 : r_count + 7'd1;
          if (w_complete && r_out_valid && !Out_Ready) r_state <= STALL;
        end
        STALL: begin
          if (Out_Ready) r_state <= RECV;
        end
        default: r_state <= RECV;
      endcase
    end
  end

`ifdef SHIFT_DESER_PARITY_EN
  logic r_perr;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_perr <= 1'b0;
    end else if (w_load) begin
      r_perr <= ^w_frame_sel;
    end
  end

  assign Parity_Err = r_perr;
`endif

  assign In_Ready  = (r_state == RECV);
  assign Out       = r_out;
  assign Out_Valid = r_out_valid;
  assign Count     = r_count;

endmodule

// File: tb/tb_shift_deserializer_64bit.sv
// tb/tb_shift_deserializer_64bit.sv - randomized and directed bench against a bit-queue reference model
module tb_shift_deserializer_64bit;

  localparam int W = 64;
`ifdef SHIFT_DESER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FR = W + PB;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic Clear = 1'b0;
  logic SerIn = 1'b0;
  logic In_Valid = 1'b0;
  logic Out_Ready = 1'b0;
  logic In_Ready;
  logic [W-1:0] Out;
  logic Out_Valid;
  logic [6:0] Count;
`ifdef SHIFT_DESER_PARITY_EN
  logic Parity_Err;
`endif

  shift_deserializer_64bit #(.WIDTH(W)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Clear      (Clear),
    .SerIn      (SerIn),
    .In_Valid   (In_Valid),
    .In_Ready   (In_Ready),
    .Out        (Out),
    .Out_Valid  (Out_Valid),
    .Out_Ready  (Out_Ready),
    .Count      (Count)
`ifdef SHIFT_DESER_PARITY_EN
    ,
    .Parity_Err (Parity_Err)
`endif
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference: frame bits accumulate as an integer; a full frame becomes a word.
  logic [64:0]  m_acc = '0;
  logic [64:0]  m_tmp;
  int           m_cnt = 0;
  bit           m_stall = 1'b0;
  logic [W-1:0] m_pend = '0;
  logic [W-1:0] m_out = '0;
  logic [W-1:0] m_word;
  bit           m_ov = 1'b0;
  bit           m_perr = 1'b0;
  bit           m_pend_perr = 1'b0;
  bit           m_cons;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_acc = '0; m_cnt = 0; m_stall = 1'b0; m_pend = '0;
      m_out = '0; m_ov = 1'b0; m_perr = 1'b0; m_pend_perr = 1'b0;
    end else begin
      m_cons = m_ov && Out_Ready;
      if (Clear) begin
        m_acc = '0; m_cnt = 0; m_stall = 1'b0;
        if (m_cons) m_ov = 1'b0;
      end else if (m_stall) begin
        if (Out_Ready) begin
          m_out = m_pend; m_perr = m_pend_perr; m_ov = 1'b1; m_stall = 1'b0;
        end
      end else begin
        if (m_cons) m_ov = 1'b0;
        if (In_Valid) begin
          m_acc = {m_acc[63:0], SerIn};
          m_cnt++;
          if (m_cnt == FR) begin
            m_tmp = m_acc >> PB;
            m_word = m_tmp[W-1:0];
            if (!m_ov) begin
              m_out = m_word; m_perr = ^m_acc; m_ov = 1'b1;
            end else begin
              m_pend = m_word; m_pend_perr = ^m_acc; m_stall = 1'b1;
            end
            m_acc = '0; m_cnt = 0;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      check("model_in_ready", 64'(In_Ready), 64'(!m_stall));
      check("model_out_valid", 64'(Out_Valid), 64'(m_ov));
      check("model_out", 64'(Out), 64'(m_out));
      check("model_count", 64'(Count), 64'(m_cnt));
`ifdef SHIFT_DESER_PARITY_EN
      check("model_parity_err", 64'(Parity_Err), 64'(m_perr));
`endif
    end
  end

  task automatic cyc(input bit v, input bit b, input bit rdy, input bit clr);
    In_Valid = v; SerIn = b; Out_Ready = rdy; Clear = clr;
    @(negedge Clk);
  endtask

  task automatic send_frame(input logic [W-1:0] w, input bit rdy, input bit rdy_last, input bit pflip);
    for (int i = W - 1; i >= 0; i--) cyc(1'b1, w[i], (i == 0 && PB == 0) ? rdy_last : rdy, 1'b0);
    if (PB == 1) cyc(1'b1, (^w) ^ pflip, rdy_last, 1'b0);
  endtask

  initial begin
    @(negedge Clk);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    check("reset_out", 64'(Out), 64'h0);
    check("reset_out_valid", 64'(Out_Valid), 64'h0);
    check("reset_in_ready", 64'(In_Ready), 64'h1);
    check("reset_count", 64'(Count), 64'h0);
    Reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    send_frame(64'hA5A5_0000_FFFF_1234, 1'b1, 1'b1, 1'b0);
    check("basic_valid", 64'(Out_Valid), 64'h1);
    check("basic_out", 64'(Out), 64'hA5A5_0000_FFFF_1234);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("basic_one_cycle", 64'(Out_Valid), 64'h0);
    check("basic_hold", 64'(Out), 64'hA5A5_0000_FFFF_1234);

    send_frame(64'h1, 1'b0, 1'b0, 1'b0);
    send_frame(64'h2, 1'b0, 1'b0, 1'b0);
    check("stall_in_ready", 64'(In_Ready), 64'h0);
    check("stall_out_first", 64'(Out), 64'h1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("stall_release_out", 64'(Out), 64'h2);
    check("stall_release_valid", 64'(Out_Valid), 64'h1);
    check("stall_release_ready", 64'(In_Ready), 64'h1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("stall_drained", 64'(Out_Valid), 64'h0);

    send_frame(64'h1111, 1'b0, 1'b0, 1'b0);
    send_frame(64'h2222, 1'b0, 1'b1, 1'b0);
    check("nobubble_out", 64'(Out), 64'h2222);
    check("nobubble_valid", 64'(Out_Valid), 64'h1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 30; i++) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("clear_count", 64'(Count), 64'h0);
    send_frame({W{1'b1}}, 1'b1, 1'b1, 1'b0);
    check("clear_ones", 64'(Out), 64'hFFFF_FFFF_FFFF_FFFF);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    #2 Reset = 1'b0;
    #1;
    check("async_out", 64'(Out), 64'h0);
    check("async_valid", 64'(Out_Valid), 64'h0);
    check("async_count", 64'(Count), 64'h0);
    check("async_ready", 64'(In_Ready), 64'h1);
    @(negedge Clk);
    Reset = 1'b1;
    send_frame(64'hDEAD_BEEF_0BAD_F00D, 1'b1, 1'b1, 1'b0);
    check("post_reset_word", 64'(Out), 64'hDEAD_BEEF_0BAD_F00D);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);

`ifdef SHIFT_DESER_PARITY_EN
    send_frame(64'h3, 1'b1, 1'b1, 1'b1);
    check("parity_bad", 64'(Parity_Err), 64'h1);
    send_frame(64'h3, 1'b1, 1'b1, 1'b0);
    check("parity_good", 64'(Parity_Err), 64'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
`endif

    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
          $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
